// File: rtl/demux1_8_deser_if.sv
// Serial-in / parallel-out bus of the deserializer: serial handshake, abort, word handshake, status.
// Modport slave is the deserializer side; master is the serial source plus word consumer.
interface demux1_8_deser_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    logic             clear;
    logic             d_in;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic [SEL_W-1:0] cur_sel;
    logic             par_err;

    modport slave (
        input  clear,
        input  d_in,
        input  d_valid,
        output d_ready,
        output y,
        output y_valid,
        input  y_ready,
        output cur_sel,
        output par_err
    );

    modport master (
        output clear,
        output d_in,
        output d_valid,
        input  d_ready,
        input  y,
        input  y_valid,
        output y_ready,
        input  cur_sel,
        input  par_err
    );
endinterface

// File: rtl/demux1_8_deser.sv
// Serial-to-parallel collector: each accepted bit lands at position cur_sel, LSB first; optional DEMUX_PARITY_EN adds an even-parity bit per frame.
// Latency: y_valid rises the cycle after the last frame bit (WIDTH cycles from the first bit when streaming).
// Backpressure: only the completing bit stalls, and only while a previous word is still unconsumed.
module demux1_8_deser #(
    parameter int WIDTH = 8,
`ifdef DEMUX_PARITY_EN
    parameter int SEL_W = 4
`else
    parameter int SEL_W = 3
`endif
) (
    input  logic clk,
    input  logic rst_n,
    demux1_8_deser_if.slave bus
);

`ifdef DEMUX_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAST);

    generate
        if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("demux1_8_deser: WIDTH must be a power of 2 and >= 2");
        end
        if (SEL_W != $clog2(LAST + 1)) begin : g_bad_sel_w
            $error("demux1_8_deser: SEL_W does not match the frame length");
        end
    endgenerate

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] col_q, col_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;

    logic             at_last;
    logic             d_ready;
    logic             accept;
    logic             complete;
    logic [WIDTH-1:0] frame_word;

    assign at_last  = (sel_q == LAST_SEL);
    assign d_ready  = !(at_last && y_valid_q && !bus.y_ready);
    // A bit offered together with clear is dropped, so it never counts as accepted.
    assign accept   = bus.d_valid && d_ready && !bus.clear;
    assign complete = accept && at_last;

`ifdef DEMUX_PARITY_EN
    assign frame_word = col_q;
`else
    assign frame_word = {bus.d_in, col_q[WIDTH-2:0]};
`endif

    always_comb begin
        sel_d     = sel_q;
        col_d     = col_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;

        if (y_valid_q && bus.y_ready) begin
            y_valid_d = 1'b0;
        end

        if (bus.clear) begin
            sel_d = '0;
            col_d = '0;
        end else if (complete) begin
            sel_d     = '0;
            col_d     = '0;
            y_d       = frame_word;
            y_valid_d = 1'b1;
        end else if (accept) begin
            sel_d = sel_q + SEL_W'(1);
            for (int k = 0; k < WIDTH; k++) begin
                if (sel_q == SEL_W'(k)) begin
                    col_d[k] = bus.d_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q     <= '0;
            col_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            col_q     <= col_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

`ifdef DEMUX_PARITY_EN
    logic par_err_q, par_err_d;

    // Even parity over data plus parity bit: a set flag means an odd total.
    always_comb begin
        par_err_d = par_err_q;
        if (complete) begin
            par_err_d = (^col_q) ^ bus.d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.d_ready = d_ready;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.cur_sel = sel_q;

endmodule

// File: tb/tb_demux1_8_deser.sv
// Bench for demux1_8_deser: directed scenarios plus random traffic, checked every cycle
// against a frame-level model (bit count, accumulated word, pending-word slot).
module tb_demux1_8_deser;
    localparam int W = 8;
`ifdef DEMUX_PARITY_EN
    localparam int FRAME = W + 1;
    localparam int SW    = 4;
`else
    localparam int FRAME = W;
    localparam int SW    = 3;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux1_8_deser_if #(.WIDTH(W), .SEL_W(SW)) bus ();

    demux1_8_deser #(.WIDTH(W), .SEL_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model: bits collected so far in the frame, their word, and the presented word.
    int           m_cnt = 0;
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] m_out = '0;
    bit           m_vld = 1'b0;
    bit           m_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit fbit(input logic [W-1:0] w, input bit p, input int i);
        return (i < W) ? w[i] : p;
    endfunction

    // Drive one cycle's inputs, compare all outputs with the model, then advance the model
    // by what the coming rising edge should do.
    task automatic tick(input bit v, input bit d, input bit yr, input bit clr, input bit rn);
        bit           rdy;
        bit           fire;
        bit           done;
        logic [W-1:0] w;
        @(negedge clk);
        rst_n       = rn;
        bus.d_valid = v;
        bus.d_in    = d;
        bus.y_ready = yr;
        bus.clear   = clr;
        #1;
        rdy = !(m_cnt == FRAME - 1 && m_vld && !yr);
        check_eq("d_ready", {31'd0, bus.d_ready}, {31'd0, rdy});
        check_eq("cur_sel", {{(32-SW){1'b0}}, bus.cur_sel}, m_cnt);
        check_eq("y_valid", {31'd0, bus.y_valid}, {31'd0, m_vld});
        check_eq("y", {{(32-W){1'b0}}, bus.y}, {{(32-W){1'b0}}, m_out});
        check_eq("par_err", {31'd0, bus.par_err}, {31'd0, m_err});
        if (!rn) begin
            m_cnt = 0;
            m_acc = '0;
            m_out = '0;
            m_vld = 1'b0;
            m_err = 1'b0;
        end else begin
            fire = v && rdy && !clr;
            done = fire && (m_cnt == FRAME - 1);
            if (done) begin
`ifdef DEMUX_PARITY_EN
                m_out = m_acc;
                m_err = ($countones(m_acc) + int'(d)) % 2 == 1;
`else
                w        = m_acc;
                w[W-1]   = d;
                m_out    = w;
`endif
                m_vld = 1'b1;
            end else if (yr) begin
                m_vld = 1'b0;
            end
            if (clr || done) begin
                m_cnt = 0;
                m_acc = '0;
            end else if (fire) begin
                m_acc[m_cnt] = d;
                m_cnt++;
            end
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit p);
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b1, fbit(w, p, i), 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic idle(input bit yr);
        tick(1'b0, 1'b0, yr, 1'b0, 1'b1);
    endtask

    initial begin
        bus.d_valid = 1'b0;
        bus.d_in    = 1'b0;
        bus.y_ready = 1'b1;
        bus.clear   = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state and first-cycle readiness.
        idle(1'b1);
        check_eq("rst_cur_sel", {{(32-SW){1'b0}}, bus.cur_sel}, 32'd0);
        check_eq("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
        check_eq("rst_d_ready", {31'd0, bus.d_ready}, 32'd1);

        // Single word, y_valid for exactly one cycle.
        send_frame(8'hAA, 1'b0);
        idle(1'b1);
        check_eq("t1_y", {24'd0, bus.y}, 32'hAA);
        check_eq("t1_vld", {31'd0, bus.y_valid}, 32'd1);
        idle(1'b1);
        check_eq("t1_vld_drop", {31'd0, bus.y_valid}, 32'd0);

        // Back-to-back words.
        send_frame(8'hAA, 1'b0);
        send_frame(8'h55, 1'b0);
        idle(1'b1);
        check_eq("t2_y", {24'd0, bus.y}, 32'h55);

        // Consumer stalls: only the completing bit waits.
        send_frame(8'hAA, 1'b0);
        for (int i = 0; i < FRAME - 1; i++) begin
            tick(1'b1, fbit(8'h0F, 1'b0, i), 1'b0, 1'b0, 1'b1);
        end
        tick(1'b1, fbit(8'h0F, 1'b0, FRAME - 1), 1'b0, 1'b0, 1'b1);
        check_eq("t3_stall", {31'd0, bus.d_ready}, 32'd0);
        check_eq("t3_hold_y", {24'd0, bus.y}, 32'hAA);
        tick(1'b1, fbit(8'h0F, 1'b0, FRAME - 1), 1'b1, 1'b0, 1'b1);
        check_eq("t3_release", {31'd0, bus.d_ready}, 32'd1);
        idle(1'b1);
        check_eq("t3_y", {24'd0, bus.y}, 32'h0F);

        // Abort a partial word with clear.
        idle(1'b1);
        repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        check_eq("t4_sel_clr", {{(32-SW){1'b0}}, bus.cur_sel}, 32'd0);
        send_frame(8'h3C, 1'b0);
        idle(1'b1);
        check_eq("t4_y", {24'd0, bus.y}, 32'h3C);

        // Reset mid-word and with a pending word.
        repeat (5) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check_eq("t5_sel", {{(32-SW){1'b0}}, bus.cur_sel}, 32'd0);
        send_frame(8'hC3, 1'b0);
        idle(1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        check_eq("t5_y_rst", {24'd0, bus.y}, 32'd0);
        check_eq("t5_vld_rst", {31'd0, bus.y_valid}, 32'd0);
        send_frame(8'hC3, 1'b0);
        idle(1'b1);
        check_eq("t5_y", {24'd0, bus.y}, 32'hC3);

`ifdef DEMUX_PARITY_EN
        send_frame(8'hAA, 1'b0);
        idle(1'b1);
        check_eq("par_ok", {31'd0, bus.par_err}, 32'd0);
        send_frame(8'hAB, 1'b0);
        idle(1'b1);
        check_eq("par_bad", {31'd0, bus.par_err}, 32'd1);
        check_eq("par_y", {24'd0, bus.y}, 32'hAB);
`endif

        // Random traffic with occasional clear and reset.
        for (int n = 0; n < 3000; n++) begin
            tick($urandom_range(3) != 0, 1'($urandom), $urandom_range(9) < 7,
                 $urandom_range(49) == 0, $urandom_range(199) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/demux1_8_deser.md
Name: demux1_8_deser

Overview:
Serial-to-parallel collector. It is the inverse of the 8:1 mux path: the mux picks bit i[sel] onto one wire, and this block routes each incoming serial bit to output bit position sel.
- An internal select counter steps through positions 0..WIDTH-1.
- Each completed word is presented on a parallel output with a valid/ready handshake.
- It sits at the receive end of the serial link driven by the mux-based serializer.

Parameters:
- WIDTH, 8: parallel word width; power of 2, >= 2.
- SEL_W, 3: select counter width; must equal clog2(WIDTH) (clog2(WIDTH+1) when DEMUX_PARITY_EN is defined).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous abort of the partial word.
- d_in  input  1  serial data bit.
- d_valid  input  1  d_in valid this cycle.
- d_ready  output  1  block can accept d_in this cycle.
- y  output  WIDTH  collected word; bit k = k-th accepted bit (LSB first).
- y_valid  output  1  y holds a complete word.
- y_ready  input  1  consumer accepts y.
- cur_sel  output  SEL_W  position the next accepted bit lands in.
- par_err  output  1  parity error flag for the word on y; valid only while y_valid=1.

Behaviour:
- Reset: rst_n sampled low at posedge clk clears the following on that edge:
  - sel_q to 0;
  - the collect register to 0;
  - y to 0;
  - y_valid to 0;
  - par_err to 0.
- Reset has priority over all other inputs and aborts any partial word or pending output. d_ready=1 in the first cycle after release.
- Accept: a bit transfers when d_valid && d_ready at posedge.
  - The bit is written to col[sel_q] and sel_q increments.
  - Bits at other positions hold.
  - Without d_valid, or with d_ready low, sel_q and col hold.
- Word completion: a transfer with sel_q == WIDTH-1 is the last bit.
  - At that edge: y <= {d_in, col[WIDTH-2:0]}, y_valid <= 1, sel_q <= 0, col <= 0.
  - y_valid rises the cycle after the last bit. Total latency is WIDTH cycles from the first bit when streaming every cycle.
- Output handshake:
  - y and par_err stay stable while y_valid && !y_ready.
  - y_valid clears on y_valid && y_ready, unless a new word completes on the same edge. In that case y_valid stays 1 and y takes the new word, so back-to-back words stream with no bubble.
- Backpressure: d_ready = !(sel_q == LAST && y_valid && !y_ready), where LAST is the final frame position.
  - Only the completing bit stalls; bits 0..LAST-1 are always accepted.
  - d_ready is combinational from state and y_ready; no input-to-d_ready path from d_valid.
- clear (when rst_n=1): sel_q <= 0 and col <= 0 at the edge.
  - Any bit offered in the same cycle is dropped.
  - y, y_valid and par_err are unaffected; a pending word stays until consumed.
  - If clear coincides with y_ready, the handshake completes normally.
- cur_sel = sel_q, registered, with no glitch.
- Wrap-around: sel_q wraps LAST -> 0 only on an accepted last bit. The counter never reaches an unused code.

Optional Feature:
DEMUX_PARITY_EN
- Defined:
  - Each frame is WIDTH data bits plus 1 even-parity bit (LAST = WIDTH).
  - The parity bit is not stored in y.
  - On completion, par_err <= ^col_data ^ parity_bit, so 1 means odd total ones.
  - The word is still presented; the consumer decides whether to discard it.
  - SEL_W must cover WIDTH+1 states.
- Undefined: frame is WIDTH bits (LAST = WIDTH-1), par_err is tied to 0, and no parity logic is present.

Test Plan:
- Reset, then stream 0,1,0,1,0,1,0,1 with d_valid=1 every cycle and y_ready=1 -> y=8'hAA, y_valid high for exactly 1 cycle, one cycle after the 8th bit; cur_sel goes 0..7 then back to 0.
- Stream 0xAA then 0x55 back-to-back with y_ready=1 -> y_valid=1 for 1 cycle per word, holding y=8'hAA then y=8'h55. No stall: d_ready stays 1 throughout.
- Hold y_ready=0 after 0xAA completes, then offer the 8 bits of 0x0F -> 7 bits accepted, d_ready=0 at sel=7, y stays 8'hAA. Raise y_ready -> 8th bit accepted on that edge, next cycle y=8'h0F.
- Offer 3 bits 1,1,1, assert clear for 1 cycle, then stream 0x3C -> y=8'h3C with no residue from the aborted bits; cur_sel=0 after clear.
- Assert rst_n=0 for 1 cycle after 5 bits, and again while y_valid=1 -> y=0, y_valid=0, cur_sel=0 next cycle. A fresh 0xC3 stream then yields y=8'hC3.
- DEMUX_PARITY_EN: send 0xAA with parity 0 -> par_err=0. Send 0xAB with parity 0 -> par_err=1, y=8'hAB. Each word completes after 9 accepted bits.
